text_line_ctrl: RTL and testbench

Sequencer and address generator for one horizontal line of 8x16 font-ROM text, such as a "PLAYER2 WINS" banner. It holds a writable character buffer and reveals the string one character at a time, typewriter style, paced by frame ticks. For every pixel it produces the registered font-ROM address and column. It sits between the game-state logic (which loads and triggers the text) and the shared font ROM / pixel colour mux.

---
 rtl/text_line_if.sv | 26 ++
 rtl/text_line_ctrl.sv | 114 +++++++++++
 tb/tb_text_line_ctrl.sv | 237 +++++++++++++++++++++++
 3 files changed

// File: rtl/text_line_if.sv
// text_line_if: bundle between game-state logic, the text line controller and the font ROM / colour mux.
interface text_line_if;
    logic        frame_start;
    logic [12:0] DrawX;
    logic [12:0] DrawY;
    logic        wr_en;
    logic [3:0]  wr_idx;
    logic [6:0]  wr_char;
    logic        start;
    logic        clear;
    logic [4:0]  len;
    logic [3:0]  reveal_ticks;
    logic        is_text;
    logic [10:0] sprite_addr;
    logic [2:0]  font_col;
    logic        busy;
    logic        done;
    modport master (
        output frame_start, DrawX, DrawY, wr_en, wr_idx, wr_char, start, clear, len, reveal_ticks,
        input  is_text, sprite_addr, font_col, busy, done
    );
    modport slave (
        input  frame_start, DrawX, DrawY, wr_en, wr_idx, wr_char, start, clear, len, reveal_ticks,
        output is_text, sprite_addr, font_col, busy, done
    );
endinterface

// File: rtl/text_line_ctrl.sv
// text_line_ctrl: typewriter-style reveal of one 8x16 font-ROM text line with registered pixel lookup.
// Optional TEXT_BLINK_EN: text blinks 16 frames on / 16 off while in HOLD.
module text_line_ctrl #(
    parameter int START_X   = 364,
    parameter int START_Y   = 400,
    parameter int MAX_CHARS = 16
) (
    input logic        Clk,
    input logic        Reset,
    text_line_if.slave tl
);
    typedef enum logic [1:0] {IDLE, REVEAL, HOLD} state_t;
    state_t      state;
    logic [6:0]  char_buf [16];
    logic [4:0]  len_l, shown, len_c;
    logic [3:0]  rt_l, tick_cnt, idx;
    logic [6:0]  dx;
    logic [3:0]  dy;
    logic [12:0] x_end;
    logic        hit;
`ifdef TEXT_BLINK_EN
    logic [4:0]  blink_cnt;
`endif
    assign len_c = (tl.len > 5'(MAX_CHARS)) ? 5'(MAX_CHARS) : tl.len;
    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            for (int i = 0; i < 16; i++) char_buf[i] <= 7'h20;
        end else if (tl.wr_en && {28'd0, tl.wr_idx} < MAX_CHARS) begin
            char_buf[tl.wr_idx] <= tl.wr_char;
        end
    end
    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            state    <= IDLE;
            shown    <= '0;
            tick_cnt <= '0;
            len_l    <= '0;
            rt_l     <= '0;
            tl.busy  <= 1'b0;
            tl.done  <= 1'b0;
`ifdef TEXT_BLINK_EN
            blink_cnt <= '0;
`endif
        end else if (tl.clear) begin
            state    <= IDLE;
            shown    <= '0;
            tick_cnt <= '0;
            tl.busy  <= 1'b0;
            tl.done  <= 1'b0;
        end else if (tl.start) begin
            len_l    <= len_c;
            rt_l     <= tl.reveal_ticks;
            tick_cnt <= '0;
            if (tl.reveal_ticks == 4'd0 || len_c == 5'd0) begin
                shown   <= len_c;
                state   <= HOLD;
                tl.busy <= 1'b0;
                tl.done <= 1'b1;
`ifdef TEXT_BLINK_EN
                blink_cnt <= '0;
`endif
            end else begin
                shown   <= '0;
                state   <= REVEAL;
                tl.busy <= 1'b1;
                tl.done <= 1'b0;
            end
        end else if (state == REVEAL && tl.frame_start) begin
            if (tick_cnt == rt_l - 4'd1) begin
                tick_cnt <= '0;
                shown    <= shown + 5'd1;
                if (shown + 5'd1 == len_l) begin
                    state   <= HOLD;
                    tl.busy <= 1'b0;
                    tl.done <= 1'b1;
`ifdef TEXT_BLINK_EN
                    blink_cnt <= '0;
`endif
                end
            end else begin
                tick_cnt <= tick_cnt + 4'd1;
            end
`ifdef TEXT_BLINK_EN
        end else if (state == HOLD && tl.frame_start) begin
            blink_cnt <= blink_cnt + 5'd1;
`endif
        end
    end
    // Only the low bits of the offsets matter once the range checks pass.
    always_comb begin
        dx    = 7'(tl.DrawX - 13'(START_X));
        dy    = 4'(tl.DrawY - 13'(START_Y));
        idx   = dx[6:3];
        x_end = 13'(START_X) + {5'd0, len_l, 3'd0};
        hit   = state != IDLE
             && tl.DrawX >= 13'(START_X) && tl.DrawX < x_end
             && tl.DrawY >= 13'(START_Y) && tl.DrawY < 13'(START_Y) + 13'd16
             && {1'b0, idx} < shown;
`ifdef TEXT_BLINK_EN
        hit   = hit && !(state == HOLD && blink_cnt[4]);
`endif
    end
    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            tl.is_text     <= 1'b0;
            tl.sprite_addr <= '0;
            tl.font_col    <= '0;
        end else begin
            tl.is_text     <= hit;
            tl.sprite_addr <= hit ? {char_buf[idx], dy} : 11'd0;
            tl.font_col    <= hit ? dx[2:0] : 3'd0;
        end
    end
endmodule

// File: tb/tb_text_line_ctrl.sv
// tb_text_line_ctrl: scenario tasks with a pixel scoreboard for text_line_ctrl.
module tb_text_line_ctrl;
    logic Clk = 1'b0;
    logic Reset = 1'b1;
    int total = 0;
    int bad = 0;
    typedef struct {
        logic        hit;
        logic [10:0] addr;
        logic [2:0]  col;
    } exp_t;
    exp_t sb[$];
    exp_t e;
    logic [6:0] msg [7] = '{7'h50, 7'h4C, 7'h41, 7'h59, 7'h45, 7'h52, 7'h32};

    text_line_if tl();
    text_line_ctrl dut (.Clk(Clk), .Reset(Reset), .tl(tl));

    always #5 Clk = ~Clk;

    task automatic tick();
        @(posedge Clk);
        #1;
    endtask

    task automatic px(input int x, input int y, input logic h, input logic [10:0] a, input logic [2:0] c);
        tl.DrawX = 13'(x);
        tl.DrawY = 13'(y);
        sb.push_back('{h, a, c});
        tick();
    endtask

    task automatic pop_cmp(input string name);
        e = sb.pop_front();
        total++;
        if (tl.is_text !== e.hit || tl.sprite_addr !== e.addr || tl.font_col !== e.col) begin
            bad++;
            $display("FAIL %s: got is_text=%b addr=%h col=%0d, want is_text=%b addr=%h col=%0d",
                     name, tl.is_text, tl.sprite_addr, tl.font_col, e.hit, e.addr, e.col);
        end
    endtask

    task automatic wr(input int i, input logic [6:0] ch);
        tl.wr_en = 1'b1;
        tl.wr_idx = 4'(i);
        tl.wr_char = ch;
        tick();
        tl.wr_en = 1'b0;
    endtask

    task automatic frames(input int n);
        for (int i = 0; i < n; i++) begin
            tl.frame_start = 1'b1;
            tick();
            tl.frame_start = 1'b0;
            tick();
        end
    endtask

    task automatic go(input int n, input int rt);
        tl.len = 5'(n);
        tl.reveal_ticks = 4'(rt);
        tl.start = 1'b1;
        tick();
        tl.start = 1'b0;
        tick();
    endtask

    task automatic chk_bd(input string name, input logic b, input logic d);
        total++;
        if (tl.busy !== b || tl.done !== d) begin
            bad++;
            $display("FAIL %s: got busy=%b done=%b, want busy=%b done=%b", name, tl.busy, tl.done, b, d);
        end
    endtask

    task automatic test_reset();
        tl.DrawX = 13'd364;
        tl.DrawY = 13'd400;
        repeat (3) tick();
        total++;
        if (tl.is_text !== 1'b0 || tl.sprite_addr !== 11'd0 || tl.font_col !== 3'd0) begin
            bad++;
            $display("FAIL reset_pix: got is_text=%b addr=%h col=%0d, want 0 0 0", tl.is_text, tl.sprite_addr, tl.font_col);
        end
        chk_bd("reset_bd", 1'b0, 1'b0);
        Reset = 1'b0;
        tick();
        px(364, 400, 1'b0, 11'd0, 3'd0);
        pop_cmp("idle_pix");
        chk_bd("idle_bd", 1'b0, 1'b0);
    endtask

    task automatic test_reveal();
        for (int i = 0; i < 7; i++) wr(i, msg[i]);
        go(7, 2);
        chk_bd("reveal_busy", 1'b1, 1'b0);
        px(364, 405, 1'b0, 11'd0, 3'd0);
        pop_cmp("none_shown");
        frames(2);
        px(364, 405, 1'b1, 11'h505, 3'd0);
        pop_cmp("first_char");
        px(372, 405, 1'b0, 11'd0, 3'd0);
        pop_cmp("second_hidden");
        frames(11);
        chk_bd("before_last", 1'b1, 1'b0);
        frames(1);
        chk_bd("after_last", 1'b0, 1'b1);
        px(415, 415, 1'b1, 11'h32F, 3'd3);
        pop_cmp("last_char");
        px(420, 405, 1'b0, 11'd0, 3'd0);
        pop_cmp("past_len");
        px(363, 405, 1'b0, 11'd0, 3'd0);
        pop_cmp("left_edge");
        px(364, 416, 1'b0, 11'd0, 3'd0);
        pop_cmp("below_row");
        px(364, 399, 1'b0, 11'd0, 3'd0);
        pop_cmp("above_row");
        wr(0, 7'h51);
        px(366, 400, 1'b1, 11'h510, 3'd2);
        pop_cmp("write_in_hold");
    endtask

    task automatic test_clear_start();
        go(7, 2);
        frames(3);
        tl.clear = 1'b1;
        tl.start = 1'b1;
        tick();
        tl.clear = 1'b0;
        tl.start = 1'b0;
        tick();
        chk_bd("clear_bd", 1'b0, 1'b0);
        for (int i = 0; i < 7; i++) begin
            px(364 + 8 * i, 400 + i, 1'b0, 11'd0, 3'd0);
            pop_cmp("clear_pix");
        end
    endtask

    task automatic test_start_frame_coincide();
        tl.len = 5'd2;
        tl.reveal_ticks = 4'd1;
        tl.start = 1'b1;
        tl.frame_start = 1'b1;
        tick();
        tl.start = 1'b0;
        tl.frame_start = 1'b0;
        tick();
        frames(1);
        chk_bd("coincide_ignored", 1'b1, 1'b0);
        frames(1);
        chk_bd("coincide_done", 1'b0, 1'b1);
    endtask

    task automatic test_zero_ticks();
        logic [6:0] c;
        go(7, 0);
        chk_bd("zero_ticks_done", 1'b0, 1'b1);
        for (int i = 0; i < 7; i++) begin
            c = (i == 0) ? 7'h51 : msg[i];
            px(364 + 8 * i + i, 401, 1'b1, {c, 4'd1}, 3'(i));
            pop_cmp("zero_ticks_pix");
        end
    endtask

    task automatic test_len_clamp();
        go(20, 0);
        px(364 + 120 + 5, 410, 1'b1, {7'h20, 4'd10}, 3'd5);
        pop_cmp("clamp_last");
        px(364 + 128, 410, 1'b0, 11'd0, 3'd0);
        pop_cmp("clamp_past");
    endtask

    task automatic test_blink();
        go(7, 0);
        frames(16);
`ifdef TEXT_BLINK_EN
        px(364, 400, 1'b0, 11'd0, 3'd0);
`else
        px(364, 400, 1'b1, 11'h510, 3'd0);
`endif
        pop_cmp("blink_16");
        chk_bd("blink_done", 1'b0, 1'b1);
        frames(16);
        px(364, 400, 1'b1, 11'h510, 3'd0);
        pop_cmp("blink_32");
    endtask

    task automatic test_back_to_back();
        for (int i = 0; i < 7; i++) begin
            px(364 + 8 * i, 400 + 15, 1'b1, {(i == 0) ? 7'h51 : msg[i], 4'd15}, 3'd0);
            pop_cmp("b2b_pix");
        end
    endtask

    task automatic test_async_reset();
        go(7, 3);
        frames(4);
        #2 Reset = 1'b1;
        #1;
        chk_bd("async_reset_bd", 1'b0, 1'b0);
        total++;
        if (tl.is_text !== 1'b0 || tl.sprite_addr !== 11'd0) begin
            bad++;
            $display("FAIL async_reset_pix: got is_text=%b addr=%h, want 0 0", tl.is_text, tl.sprite_addr);
        end
        tick();
        Reset = 1'b0;
        go(1, 0);
        px(364, 400, 1'b1, {7'h20, 4'd0}, 3'd0);
        pop_cmp("buffer_spaces");
    endtask

    initial begin
        tl.frame_start = 1'b0;
        tl.wr_en = 1'b0;
        tl.wr_idx = '0;
        tl.wr_char = '0;
        tl.start = 1'b0;
        tl.clear = 1'b0;
        tl.len = '0;
        tl.reveal_ticks = '0;
        tl.DrawX = '0;
        tl.DrawY = '0;
        test_reset();
        test_reveal();
        test_clear_start();
        test_start_frame_coincide();
        test_zero_ticks();
        test_len_clamp();
        test_blink();
        test_back_to_back();
        test_async_reset();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
